transaction_control: RTL and testbench
======================================

# transaction_control

Sequencing controller that sits directly upstream of the transaction datapath. It walks one transfer from start to finish. It reads both player records from ledger memory and latches the player choice, amount and key as the user confirms each one. It then drives the datapath `process` code through the amount check and the key check, and finally commits the datapath's result back to memory. Outcome is reported as a held status code, with timeouts on both checks.

## Interface
- `CHECK_TIMEOUT`, 255: cycles allowed per check before it is declared failed (1..255).
- `MEM_LATENCY`, 1: cycles from `mem_read` to valid `memory_values` (1..3).
- `MAX_KEY_TRIES`, 3: key attempts allowed when retry is compiled in (1..7).

Ports:
- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `go` in 1: one-cycle pulse that starts a transaction; honoured only in IDLE.
- `confirm` in 1: one-cycle pulse meaning the current user entry is valid.
- `cancel` in 1: abort; from any non-IDLE state, go to IDLE next cycle.
- `done_step` in 1: datapath check-passed flag.
- `process` out 3: datapath step code (000 idle, 001 amount, 010 key, 011 commit).
- `load_player`, `load_amount`, `load_key`, `load_register` out 1 each: one-cycle load strobes.
- `mem_read` out 1: one-cycle ledger read request.
- `mem_write` out 1: one-cycle write of datapath `result_out`.
- `busy` out 1: high in every state except IDLE.
- `status` out 2: 00 none, 01 committed, 10 amount rejected, 11 key rejected.

## Operation
- States are IDLE, FETCH, LATCH, WAIT_PLAYER, WAIT_AMOUNT, CHK_AMOUNT, WAIT_KEY, CHK_KEY, COMMIT and DONE.
- IDLE → FETCH on `go`, which also clears `status` to 00.
- FETCH pulses `mem_read` on entry, waits `MEM_LATENCY` cycles, then moves to LATCH.
- LATCH pulses `load_register` for one cycle, then moves to WAIT_PLAYER.
- WAIT_PLAYER: on `confirm`, pulse `load_player` and move to WAIT_AMOUNT.
- WAIT_AMOUNT: on `confirm`, pulse `load_amount` and move to CHK_AMOUNT.
- WAIT_KEY: on `confirm`, pulse `load_key` and move to CHK_KEY.
- CHK_AMOUNT / CHK_KEY drive `process` = 001 / 010 and start the step timer.
  - `done_step` is ignored in the first cycle of the state, because it is stale.
  - From the second cycle, `done_step`=1 advances: CHK_AMOUNT → WAIT_KEY, CHK_KEY → COMMIT.
  - If the timer reaches `CHECK_TIMEOUT` first, go to DONE with `status` 10 or 11.
- COMMIT drives `process`=011, pulses `mem_write` on its second cycle, then sets `status`=01 and moves to DONE.
- DONE holds `status` and moves to IDLE the next cycle. `status` then persists until the next `go`.
- `process` is 000 in every state other than CHK_AMOUNT, CHK_KEY and COMMIT.
- Simultaneous events:
  - `cancel` beats everything else, including `confirm` and `done_step` in the same cycle.
  - A cancel in COMMIT before the `mem_write` cycle suppresses the write.
  - `go` while busy is ignored.
  - `confirm` outside the WAIT states is ignored.
- A cancel leaves `status` at 00.

## Timing
- Reset, asserted at any time including mid-transaction, forces:
  - state IDLE;
  - `process`=000;
  - all strobes 0;
  - `busy`=0;
  - `status`=00;
  - timer and try counter cleared.
- All outputs are registered. Strobes are exactly one cycle wide.
- `go` → `mem_read` is 1 cycle.
- `mem_read` → `load_register` is `MEM_LATENCY`+1 cycles.
- The earliest pass of a check is 2 cycles after entering it.
- A timeout fires on cycle `CHECK_TIMEOUT`+1 in the check state.
- The timer is an 8-bit saturating counter and is cleared on every state change.

## Configuration
- `TXN_KEY_RETRY_EN` defined:
  - A CHK_KEY timeout increments the try counter and returns to WAIT_KEY.
  - The rejection (`status`=11) happens only when the counter reaches `MAX_KEY_TRIES`.
  - The counter is 3 bits and is cleared in IDLE.
- `TXN_KEY_RETRY_EN` undefined: there is no try counter, and the first key timeout rejects.

## Structure
- Package `txn_pkg` holds:
  - the state encoding;
  - the process codes `PROC_IDLE`, `PROC_AMOUNT`, `PROC_KEY`, `PROC_COMMIT`;
  - the status codes `ST_NONE`, `ST_OK`, `ST_BAD_AMOUNT`, `ST_BAD_KEY`.
- Sub-module `step_timer` is the clearable, saturating 8-bit cycle counter with a terminal-count output. The FSM lives in `transaction_control`.

## Test plan
- **Happy path:** `MEM_LATENCY`=1. Drive `go`, then 3 confirms, with `done_step`=1 from the 2nd cycle of each check.
  - One pulse each of `mem_read`, `load_register`, `load_player`, `load_amount`, `load_key`, `mem_write`.
  - `status`=01 and `busy` returns to 0.
- **Insufficient funds:** `CHECK_TIMEOUT`=4 and `done_step` held 0 in CHK_AMOUNT.
  - DONE is entered after 5 cycles with `status`=10.
  - `load_key` and `mem_write` never pulse.
- **Bad key, retry off:** `done_step` stays 0 in CHK_KEY, so `status`=11 after one timeout.
- **Bad key, retry on:** `TXN_KEY_RETRY_EN` defined, `MAX_KEY_TRIES`=3.
  - Two failing key attempts return to WAIT_KEY.
  - A third attempt passing gives `status`=01.
  - Three failing attempts give `status`=11.
- **Cancel and ignored `go`:** `cancel` in the same cycle as `confirm` in WAIT_AMOUNT.
  - IDLE next cycle, no `load_amount`, `status`=00.
  - `go` while busy has no effect.
- **Reset mid-operation:** `reset` pulsed in COMMIT's first cycle.
  - All outputs go to reset values immediately and there is no `mem_write`.
  - A following `go` starts cleanly.

Source files
------------

// File: rtl/txn_pkg.sv
// Shared encodings for the transaction sequencing controller: FSM states,
// datapath process codes and held status codes.
package txn_pkg;

   typedef enum logic [3:0] {
      S_IDLE        = 4'd0,
      S_FETCH       = 4'd1,
      S_LATCH       = 4'd2,
      S_WAIT_PLAYER = 4'd3,
      S_WAIT_AMOUNT = 4'd4,
      S_CHK_AMOUNT  = 4'd5,
      S_WAIT_KEY    = 4'd6,
      S_CHK_KEY     = 4'd7,
      S_COMMIT      = 4'd8,
      S_DONE        = 4'd9
   } state_t;

   localparam logic [2:0] PROC_IDLE   = 3'b000;
   localparam logic [2:0] PROC_AMOUNT = 3'b001;
   localparam logic [2:0] PROC_KEY    = 3'b010;
   localparam logic [2:0] PROC_COMMIT = 3'b011;

   localparam logic [1:0] ST_NONE       = 2'b00;
   localparam logic [1:0] ST_OK         = 2'b01;
   localparam logic [1:0] ST_BAD_AMOUNT = 2'b10;
   localparam logic [1:0] ST_BAD_KEY    = 2'b11;

   // Datapath step code presented while the FSM sits in a given state.
   function automatic logic [2:0] proc_of(state_t s);
      case (s)
         S_CHK_AMOUNT: proc_of = PROC_AMOUNT;
         S_CHK_KEY:    proc_of = PROC_KEY;
         S_COMMIT:     proc_of = PROC_COMMIT;
         default:      proc_of = PROC_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/transaction_control_step_timer.sv
// Clearable, saturating 8-bit cycle counter; tc_o flags count_o == limit_i.
module step_timer
   import txn_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear_i,
   input  logic [7:0] limit_i,
   output logic [7:0] count_o,
   output logic       tc_o
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // Next count: restart on clear, otherwise count up and stick at all-ones.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = 8'd0;
      end else if (count_q != 8'hFF) begin
         count_d = count_q + 8'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == limit_i);

endmodule

// File: rtl/transaction_control.sv
// Transfer sequencing FSM driving the transaction datapath and ledger memory.
// Optional key retry is compiled in with TXN_KEY_RETRY_EN.
module transaction_control
   import txn_pkg::*;
#(
   parameter int CHECK_TIMEOUT = 255,
   parameter int MEM_LATENCY   = 1,
   parameter int MAX_KEY_TRIES = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  logic       confirm,
   input  logic       cancel,
   input  logic       done_step,
   output logic [2:0] process,
   output logic       load_player,
   output logic       load_amount,
   output logic       load_key,
   output logic       load_register,
   output logic       mem_read,
   output logic       mem_write,
   output logic       busy,
   output logic [1:0] status
);

   localparam logic [7:0] FETCH_WAIT = 8'(MEM_LATENCY);
   localparam logic [7:0] TIMEOUT    = 8'(CHECK_TIMEOUT);

   state_t     state_q, state_d;
   logic [1:0] status_q, status_d;
   logic [2:0] process_q, process_d;
   logic       busy_q, busy_d;
   logic       mem_read_q, mem_read_d;
   logic       mem_write_q, mem_write_d;
   logic       load_register_q, load_register_d;
   logic       load_player_q, load_player_d;
   logic       load_amount_q, load_amount_d;
   logic       load_key_q, load_key_d;
   logic [7:0] count_s;
   logic       timeout_s;
   logic       timer_clear_s;
   logic       check_pass_s;

`ifdef TXN_KEY_RETRY_EN
   localparam logic [3:0] MAX_TRIES = 4'(MAX_KEY_TRIES);
   logic [2:0] tries_q, tries_d;
`endif

   assign timer_clear_s = (state_d != state_q);
   // A done_step seen in the first cycle of a check belongs to the previous step.
   assign check_pass_s  = done_step && (count_s != 8'd0);
   assign busy_d        = (state_d != S_IDLE);
   assign process_d     = proc_of(state_d);

   step_timer u_step_timer (
      .clock   (clock),
      .reset   (reset),
      .clear_i (timer_clear_s),
      .limit_i (TIMEOUT),
      .count_o (count_s),
      .tc_o    (timeout_s)
   );

   // Next-state, next-status and strobe decode.
   always_comb begin
      state_d         = state_q;
      status_d        = status_q;
      mem_read_d      = 1'b0;
      mem_write_d     = 1'b0;
      load_register_d = 1'b0;
      load_player_d   = 1'b0;
      load_amount_d   = 1'b0;
      load_key_d      = 1'b0;
`ifdef TXN_KEY_RETRY_EN
      tries_d         = tries_q;
`endif
      if (cancel && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
`ifdef TXN_KEY_RETRY_EN
               tries_d = 3'd0;
`endif
               if (go) begin
                  state_d    = S_FETCH;
                  status_d   = ST_NONE;
                  mem_read_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FETCH: begin
               if (count_s == FETCH_WAIT) begin
                  state_d         = S_LATCH;
                  load_register_d = 1'b1;
               end else begin
                  state_d = S_FETCH;
               end
            end
            S_LATCH: state_d = S_WAIT_PLAYER;
            S_WAIT_PLAYER: begin
               if (confirm) begin
                  state_d       = S_WAIT_AMOUNT;
                  load_player_d = 1'b1;
               end else begin
                  state_d = S_WAIT_PLAYER;
               end
            end
            S_WAIT_AMOUNT: begin
               if (confirm) begin
                  state_d       = S_CHK_AMOUNT;
                  load_amount_d = 1'b1;
               end else begin
                  state_d = S_WAIT_AMOUNT;
               end
            end
            S_CHK_AMOUNT: begin
               if (check_pass_s) begin
                  state_d = S_WAIT_KEY;
               end else if (timeout_s) begin
                  state_d  = S_DONE;
                  status_d = ST_BAD_AMOUNT;
               end else begin
                  state_d = S_CHK_AMOUNT;
               end
            end
            S_WAIT_KEY: begin
               if (confirm) begin
                  state_d    = S_CHK_KEY;
                  load_key_d = 1'b1;
               end else begin
                  state_d = S_WAIT_KEY;
               end
            end
            S_CHK_KEY: begin
               if (check_pass_s) begin
                  state_d = S_COMMIT;
               end else if (timeout_s) begin
`ifdef TXN_KEY_RETRY_EN
                  if (({1'b0, tries_q} + 4'd1) >= MAX_TRIES) begin
                     state_d  = S_DONE;
                     status_d = ST_BAD_KEY;
                  end else begin
                     state_d = S_WAIT_KEY;
                     tries_d = tries_q + 3'd1;
                  end
`else
                  state_d  = S_DONE;
                  status_d = ST_BAD_KEY;
`endif
               end else begin
                  state_d = S_CHK_KEY;
               end
            end
            S_COMMIT: begin
               // First cycle lets the datapath settle; the write lands on the second.
               if (count_s == 8'd0) begin
                  mem_write_d = 1'b1;
               end else begin
                  state_d  = S_DONE;
                  status_d = ST_OK;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, status and registered output stage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         status_q        <= ST_NONE;
         process_q       <= PROC_IDLE;
         busy_q          <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_write_q     <= 1'b0;
         load_register_q <= 1'b0;
         load_player_q   <= 1'b0;
         load_amount_q   <= 1'b0;
         load_key_q      <= 1'b0;
`ifdef TXN_KEY_RETRY_EN
         tries_q         <= 3'd0;
`endif
      end else begin
         state_q         <= state_d;
         status_q        <= status_d;
         process_q       <= process_d;
         busy_q          <= busy_d;
         mem_read_q      <= mem_read_d;
         mem_write_q     <= mem_write_d;
         load_register_q <= load_register_d;
         load_player_q   <= load_player_d;
         load_amount_q   <= load_amount_d;
         load_key_q      <= load_key_d;
`ifdef TXN_KEY_RETRY_EN
         tries_q         <= tries_d;
`endif
      end
   end

   assign process       = process_q;
   assign busy          = busy_q;
   assign status        = status_q;
   assign mem_read      = mem_read_q;
   assign mem_write     = mem_write_q;
   assign load_register = load_register_q;
   assign load_player   = load_player_q;
   assign load_amount   = load_amount_q;
   assign load_key      = load_key_q;

endmodule

// File: tb/tb_transaction_control.sv
// Bench for transaction_control: per-transaction timelines are planned from the
// transfer rules, then replayed cycle by cycle against the DUT outputs.
module tb_transaction_control;
   import txn_pkg::*;

   localparam int CT  = 4;
   localparam int ML  = 1;
   localparam int MKT = 3;
   localparam int N   = 128;
`ifdef TXN_KEY_RETRY_EN
   localparam int KEY_TRIES = MKT;
`else
   localparam int KEY_TRIES = 1;
`endif

   logic       clock, reset, go, confirm, cancel, done_step;
   logic [2:0] process;
   logic       load_player, load_amount, load_key, load_register;
   logic       mem_read, mem_write, busy;
   logic [1:0] status;

   transaction_control #(
      .CHECK_TIMEOUT (CT),
      .MEM_LATENCY   (ML),
      .MAX_KEY_TRIES (MKT)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .go            (go),
      .confirm       (confirm),
      .cancel        (cancel),
      .done_step     (done_step),
      .process       (process),
      .load_player   (load_player),
      .load_amount   (load_amount),
      .load_key      (load_key),
      .load_register (load_register),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .busy          (busy),
      .status        (status)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   // Expected strobes {mem_read, load_register, load_player, load_amount, load_key, mem_write}.
   logic [5:0] e_strb [N];
   logic       e_busy [N];
   logic [2:0] e_proc [N];
   logic [1:0] e_st   [N];
   logic       d_go [N], d_cf [N], d_dn [N], d_cn [N];
   int         plan_len, c_amt_cf, c_commit, c_done;
   logic [1:0] prev_status;

   task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic wait_phase(input int start, input int dly, output int nxt);
      for (int i = start; i <= start + dly; i++) e_busy[i] = 1'b1;
      d_cf[start + dly] = 1'b1;
      nxt = start + dly + 1;
   endtask

   // k >= 2: done_step rises on the k-th cycle of the check; k == 0: never passes.
   task automatic check_phase(input int start, input int k, input logic [2:0] pc,
                              output int nxt, output bit passed);
      int len;
      passed = (k >= 2);
      len = passed ? k : CT + 1;
      for (int i = start; i < start + len; i++) begin
         e_busy[i] = 1'b1;
         e_proc[i] = pc;
         d_cf[i]   = ($urandom_range(0, 2) == 0);
      end
      d_dn[start] = 1'b1;
      if (passed) d_dn[start + k - 1] = 1'b1;
      nxt = start + len;
   endtask

   task automatic build_plan(input int dp, input int da, input int dk, input int amt_k,
                             input int k0, input int k1, input int k2);
      int t;
      bit ok;
      int keys [3];
      logic [1:0] fin;
      keys[0] = k0; keys[1] = k1; keys[2] = k2;
      for (int i = 0; i < N; i++) begin
         e_strb[i] = 6'd0; e_busy[i] = 1'b0; e_proc[i] = PROC_IDLE; e_st[i] = prev_status;
         d_go[i] = 1'b0; d_cf[i] = 1'b0; d_dn[i] = 1'b0; d_cn[i] = 1'b0;
      end
      c_commit = -1;
      d_go[0] = 1'b1;
      for (int i = 1; i <= ML + 2; i++) e_busy[i] = 1'b1;
      e_strb[1]      = 6'b100000;
      e_strb[ML + 2] = 6'b010000;
      wait_phase(ML + 3, dp, t);
      e_strb[t] = 6'b001000;
      c_amt_cf = t + da;
      wait_phase(t, da, t);
      e_strb[t] = 6'b000100;
      check_phase(t, amt_k, PROC_AMOUNT, t, ok);
      if (!ok) begin
         fin = ST_BAD_AMOUNT;
      end else begin
         for (int a = 0; a < KEY_TRIES; a++) begin
            wait_phase(t, dk, t);
            e_strb[t] = 6'b000010;
            check_phase(t, keys[a], PROC_KEY, t, ok);
            if (ok) break;
         end
         if (ok) begin
            c_commit = t;
            e_busy[t] = 1'b1; e_busy[t + 1] = 1'b1;
            e_proc[t] = PROC_COMMIT; e_proc[t + 1] = PROC_COMMIT;
            e_strb[t + 1] = 6'b000001;
            t = t + 2;
            fin = ST_OK;
         end else begin
            fin = ST_BAD_KEY;
         end
      end
      c_done = t;
      e_busy[t] = 1'b1;
      for (int i = 1; i < t; i++) e_st[i] = ST_NONE;
      for (int i = t; i < N; i++) e_st[i] = fin;
      for (int i = 1; i <= t; i++) d_go[i] = ($urandom_range(0, 3) == 0);
      plan_len = t + 3;
      prev_status = fin;
   endtask

   task automatic apply_cancel(input int c);
      d_cn[c] = 1'b1;
      for (int i = c + 1; i < N; i++) begin
         e_strb[i] = 6'd0; e_busy[i] = 1'b0; e_proc[i] = PROC_IDLE; e_st[i] = ST_NONE;
         d_go[i] = 1'b0;
      end
      plan_len = c + 3;
      prev_status = ST_NONE;
   endtask

   task automatic run_plan(input int upto);
      for (int i = 0; i <= upto; i++) begin
         @(posedge clock);
         #1;
         chk("strobes", i, {2'b00, mem_read, load_register, load_player, load_amount, load_key, mem_write},
             {2'b00, e_strb[i]});
         chk("busy_process", i, {4'd0, busy, process}, {4'd0, e_busy[i], e_proc[i]});
         chk("status", i, {6'd0, status}, {6'd0, e_st[i]});
         go = d_go[i]; confirm = d_cf[i]; done_step = d_dn[i]; cancel = d_cn[i];
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dp, da, dk, ak, k0, k1, k2;
      go = 1'b0; confirm = 1'b0; cancel = 1'b0; done_step = 1'b0; reset = 1'b0;
      prev_status = ST_NONE;
      #2 reset = 1'b1;
      #3;
      chk("reset_outputs", 0, {busy, mem_read, load_register, load_player, load_amount, load_key, mem_write, process, status}, 12'd0);
      repeat (2) @(posedge clock);
      @(negedge clock) reset = 1'b0;

      // Happy path, done_step from the second cycle of each check.
      build_plan(0, 0, 0, 2, 2, 2, 2);
      run_plan(plan_len - 1);
      // Amount check times out.
      build_plan(1, 0, 1, 0, 2, 2, 2);
      run_plan(plan_len - 1);
      // Key never confirmed by the datapath.
      build_plan(0, 1, 0, 3, 0, 0, 0);
      run_plan(plan_len - 1);
      // Two failing key attempts then a pass (rejects at once without retry).
      build_plan(0, 0, 1, 2, 0, 0, 3);
      run_plan(plan_len - 1);
      // Cancel together with the amount confirm.
      build_plan(1, 2, 0, 2, 2, 2, 2);
      apply_cancel(c_amt_cf);
      run_plan(plan_len - 1);
      // Cancel in the first commit cycle suppresses the write.
      build_plan(0, 0, 0, 2, 2, 2, 2);
      apply_cancel(c_commit);
      run_plan(plan_len - 1);

      // Reset pulsed during the first commit cycle.
      build_plan(0, 1, 0, 2, 3, 2, 2);
      run_plan(c_commit);
      #2 reset = 1'b1;
      #1;
      chk("reset_mid_commit", c_commit, {busy, mem_read, load_register, load_player, load_amount, load_key, mem_write, process, status}, 12'd0);
      go = 1'b0; confirm = 1'b0; cancel = 1'b0; done_step = 1'b0;
      @(negedge clock) reset = 1'b0;
      prev_status = ST_NONE;
      build_plan(0, 0, 0, 2, 2, 2, 2);
      run_plan(plan_len - 1);

      for (int n = 0; n < 20; n++) begin
         dp = $urandom_range(0, 3);
         da = $urandom_range(0, 3);
         dk = $urandom_range(0, 3);
         ak = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(2, CT);
         k0 = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, CT);
         k1 = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, CT);
         k2 = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(2, CT);
         build_plan(dp, da, dk, ak, k0, k1, k2);
         if ($urandom_range(0, 3) == 0) apply_cancel($urandom_range(1, c_done - 1));
         run_plan(plan_len - 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
